// File: rtl/memory_cycle_if.sv
// M-stage inputs and registered W-stage outputs of the RV32I memory stage.
interface memory_cycle_if;
    logic        Valid_M;
    logic        RegWrite_M;
    logic        ResultSrc_M;
    logic        MemWrite_M;
    logic [2:0]  funct3_M;
    logic [31:0] AluResult_M;
    logic [31:0] WriteData_M;
    logic [4:0]  Rd_M;
    logic [31:0] PCPlus4_M;

    logic        RegWrite_W;
    logic        ResultSrc_W;
    logic [31:0] ReadData_W;
    logic [31:0] AluResult_W;
    logic [4:0]  Rd_W;
    logic [31:0] PCPlus4_W;
    logic        MisalignFault_W;

    // master is the execute side feeding M and observing W
    modport master (
        output Valid_M, RegWrite_M, ResultSrc_M, MemWrite_M, funct3_M,
               AluResult_M, WriteData_M, Rd_M, PCPlus4_M,
        input  RegWrite_W, ResultSrc_W, ReadData_W, AluResult_W, Rd_W,
               PCPlus4_W, MisalignFault_W
    );

    modport slave (
        input  Valid_M, RegWrite_M, ResultSrc_M, MemWrite_M, funct3_M,
               AluResult_M, WriteData_M, Rd_M, PCPlus4_M,
        output RegWrite_W, ResultSrc_W, ReadData_W, AluResult_W, Rd_W,
               PCPlus4_W, MisalignFault_W
    );
endinterface

// File: rtl/memory_cycle.sv
// RV32I memory stage: data memory with byte/half/word loads and stores, alignment checking.
// Latency: stores commit at the edge, load data reaches W one cycle after M.
// Backpressure: none; W registers update every non-reset cycle.
module memory_cycle #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          rst,
    memory_cycle_if.slave bus
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        regWrite;
        logic        resultSrc;
        logic [31:0] readData;
        logic [31:0] aluResult;
        logic [4:0]  rd;
        logic [31:0] pcPlus4;
        logic        misalignFault;
    } wStage_t;

    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] wordIdx;
    logic [1:0]        byteOff;
    logic              memAccess;
    logic              badAccess;
    logic              misalign;
    logic              storeEn;
    logic [3:0]        byteEn;
    logic [31:0]       storeWord;
    logic [31:0]       loadWord;
    logic [7:0]        laneByte;
    logic [15:0]       laneHalf;
    logic [31:0]       loadExt;
    wStage_t           wNext;
    wStage_t           wReg;

    assign wordIdx   = bus.AluResult_M[ADDR_W+1:2];
    assign byteOff   = bus.AluResult_M[1:0];
    assign memAccess = bus.ResultSrc_M | bus.MemWrite_M;

    // Stores only know B/H/W; unsigned codes are legal only on loads.
    always_comb begin
        badAccess = 1'b1;
        case (bus.funct3_M)
            F3_B:  badAccess = 1'b0;
            F3_H:  badAccess = byteOff[0];
            F3_W:  badAccess = (byteOff != 2'b00);
            F3_BU: badAccess = bus.MemWrite_M;
            F3_HU: badAccess = bus.MemWrite_M | byteOff[0];
            default: badAccess = 1'b1;
        endcase
    end

    assign misalign = bus.Valid_M & memAccess & badAccess;
    assign storeEn  = rst & bus.Valid_M & bus.MemWrite_M & ~misalign;

    always_comb begin
        byteEn    = 4'b0000;
        storeWord = bus.WriteData_M;
        case (bus.funct3_M)
            F3_B: begin
                byteEn    = 4'b0001 << byteOff;
                storeWord = {4{bus.WriteData_M[7:0]}};
            end
            F3_H: begin
                byteEn    = byteOff[1] ? 4'b1100 : 4'b0011;
                storeWord = {2{bus.WriteData_M[15:0]}};
            end
            F3_W: begin
                byteEn    = 4'b1111;
                storeWord = bus.WriteData_M;
            end
            default: begin
                byteEn    = 4'b0000;
                storeWord = bus.WriteData_M;
            end
        endcase
    end

    // Memory contents survive reset; only the store enable is gated by it.
    always_ff @(posedge clk) begin
        if (storeEn) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][i*8 +: 8] <= storeWord[i*8 +: 8];
                end
            end
        end
    end

    // Combinational read sees a store committed at the previous edge.
    assign loadWord = mem[wordIdx];
    assign laneByte = loadWord[{byteOff, 3'b000} +: 8];
    assign laneHalf = byteOff[1] ? loadWord[31:16] : loadWord[15:0];

    always_comb begin
        loadExt = 32'd0;
        case (bus.funct3_M)
            F3_B:    loadExt = {{24{laneByte[7]}}, laneByte};
            F3_BU:   loadExt = {24'd0, laneByte};
            F3_H:    loadExt = {{16{laneHalf[15]}}, laneHalf};
            F3_HU:   loadExt = {16'd0, laneHalf};
            F3_W:    loadExt = loadWord;
            default: loadExt = 32'd0;
        endcase
    end

    always_comb begin
        wNext.regWrite      = bus.Valid_M & bus.RegWrite_M & ~misalign;
        wNext.resultSrc     = bus.ResultSrc_M;
        wNext.readData      = (bus.ResultSrc_M & ~misalign) ? loadExt : 32'd0;
        wNext.aluResult     = bus.AluResult_M;
        wNext.rd            = bus.Rd_M;
        wNext.pcPlus4       = bus.PCPlus4_M;
        wNext.misalignFault = misalign;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wReg <= '0;
        end else begin
            wReg <= wNext;
        end
    end

    assign bus.RegWrite_W      = wReg.regWrite;
    assign bus.ResultSrc_W     = wReg.resultSrc;
    assign bus.ReadData_W      = wReg.readData;
    assign bus.AluResult_W     = wReg.aluResult;
    assign bus.Rd_W            = wReg.rd;
    assign bus.PCPlus4_W       = wReg.pcPlus4;
    assign bus.MisalignFault_W = wReg.misalignFault;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: loads, stores, alignment faults, reset, bubbles and wrap.
module tb_memory_cycle;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nTests = 0;
    int   nFail  = 0;

    memory_cycle_if bus ();

    memory_cycle #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present one M-stage instruction, clock it into W, sample 1 time unit later.
    task automatic issue(input logic valid, input logic regW, input logic resSrc, input logic memW,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc);
        bus.Valid_M     = valid;
        bus.RegWrite_M  = regW;
        bus.ResultSrc_M = resSrc;
        bus.MemWrite_M  = memW;
        bus.funct3_M    = f3;
        bus.AluResult_M = addr;
        bus.WriteData_M = wd;
        bus.Rd_M        = rd;
        bus.PCPlus4_M   = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        issue(1'b1, 1'b0, 1'b0, 1'b1, f3, addr, wd, 5'd0, 32'h0000_0004);
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        issue(1'b1, 1'b1, 1'b1, 1'b0, f3, addr, 32'd0, rd, 32'h0000_0100);
    endtask

    initial begin
        // Reset with a live store pending: outputs clear despite nonzero inputs.
        issue(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hAAAA_AAAA, 5'd5, 32'h200);
        checkVal("rst_regwrite", {31'd0, bus.RegWrite_W}, 32'd0);
        checkVal("rst_alu", bus.AluResult_W, 32'd0);
        checkVal("rst_pc", bus.PCPlus4_W, 32'd0);
        checkVal("rst_rd", {27'd0, bus.Rd_W}, 32'd0);

        rst = 1'b1;
        store(3'b010, 32'h10, 32'h1111_1111);
        checkVal("sw_regwrite", {31'd0, bus.RegWrite_W}, 32'd0);
        checkVal("sw_fault", {31'd0, bus.MisalignFault_W}, 32'd0);

        // Two reset cycles with a store to 0x10 that must not land.
        rst = 1'b0;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hBADB_AD00, 5'd5, 32'h300);
        issue(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hBADB_AD00, 5'd5, 32'h300);
        checkVal("rst2_regwrite", {31'd0, bus.RegWrite_W}, 32'd0);
        checkVal("rst2_alu", bus.AluResult_W, 32'd0);
        checkVal("rst2_pc", bus.PCPlus4_W, 32'd0);
        checkVal("rst2_resultsrc", {31'd0, bus.ResultSrc_W}, 32'd0);
        rst = 1'b1;
        load(3'b010, 32'h10, 5'd3);
        checkVal("rst_lw_data", bus.ReadData_W, 32'h1111_1111);

        // Word round trip: store then load on the very next cycle.
        store(3'b010, 32'h20, 32'hDEAD_BEEF);
        issue(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 5'd7, 32'h204);
        checkVal("lw_data", bus.ReadData_W, 32'hDEAD_BEEF);
        checkVal("lw_regwrite", {31'd0, bus.RegWrite_W}, 32'd1);
        checkVal("lw_rd", {27'd0, bus.Rd_W}, 32'd7);
        checkVal("lw_pc", bus.PCPlus4_W, 32'h204);
        checkVal("lw_resultsrc", {31'd0, bus.ResultSrc_W}, 32'd1);
        checkVal("lw_fault", {31'd0, bus.MisalignFault_W}, 32'd0);

        // Byte lanes.
        store(3'b010, 32'h40, 32'h0000_0000);
        store(3'b000, 32'h42, 32'hFFFF_FF80);
        load(3'b000, 32'h42, 5'd1);
        checkVal("lb_42", bus.ReadData_W, 32'hFFFF_FF80);
        load(3'b100, 32'h42, 5'd1);
        checkVal("lbu_42", bus.ReadData_W, 32'h0000_0080);
        load(3'b010, 32'h40, 5'd1);
        checkVal("lw_40_after_sb", bus.ReadData_W, 32'h0080_0000);

        // Halfwords: word at 0x40 becomes 0x00808001.
        store(3'b001, 32'h40, 32'h1234_8001);
        load(3'b001, 32'h40, 5'd2);
        checkVal("lh_40", bus.ReadData_W, 32'hFFFF_8001);
        load(3'b101, 32'h40, 5'd2);
        checkVal("lhu_40", bus.ReadData_W, 32'h0000_8001);
        load(3'b001, 32'h42, 5'd2);
        checkVal("lh_42", bus.ReadData_W, 32'h0000_0080);
        load(3'b000, 32'h41, 5'd2);
        checkVal("lb_41", bus.ReadData_W, 32'hFFFF_FF80);

        // Misaligned accesses.
        load(3'b010, 32'h21, 5'd4);
        checkVal("lw21_fault", {31'd0, bus.MisalignFault_W}, 32'd1);
        checkVal("lw21_regwrite", {31'd0, bus.RegWrite_W}, 32'd0);
        checkVal("lw21_data", bus.ReadData_W, 32'd0);
        store(3'b001, 32'h43, 32'h0000_FFFF);
        checkVal("sh43_fault", {31'd0, bus.MisalignFault_W}, 32'd1);
        load(3'b010, 32'h40, 5'd4);
        checkVal("sh43_unchanged", bus.ReadData_W, 32'h0080_8001);

        // Unused funct3 codes.
        store(3'b100, 32'h40, 32'hFFFF_FFFF);
        checkVal("sbu_fault", {31'd0, bus.MisalignFault_W}, 32'd1);
        load(3'b011, 32'h40, 5'd4);
        checkVal("ld011_fault", {31'd0, bus.MisalignFault_W}, 32'd1);
        checkVal("ld011_data", bus.ReadData_W, 32'd0);
        load(3'b010, 32'h40, 5'd4);
        checkVal("sbu_unchanged", bus.ReadData_W, 32'h0080_8001);

        // Bubble carrying a store.
        issue(1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFE_CAFE, 5'd6, 32'h400);
        checkVal("bub_regwrite", {31'd0, bus.RegWrite_W}, 32'd0);
        checkVal("bub_fault", {31'd0, bus.MisalignFault_W}, 32'd0);
        load(3'b010, 32'h40, 5'd4);
        checkVal("bub_unchanged", bus.ReadData_W, 32'h0080_8001);

        // Address wrap modulo DEPTH*4.
        store(3'b010, DEPTH * 4 + 32'h8, 32'h0000_0005);
        load(3'b010, 32'h8, 5'd8);
        checkVal("wrap_lw", bus.ReadData_W, 32'h0000_0005);

        // ALU pass-through.
        issue(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h1234, 32'hFFFF_FFFF, 5'd9, 32'h5554);
        checkVal("alu_alu", bus.AluResult_W, 32'h1234);
        checkVal("alu_data", bus.ReadData_W, 32'd0);
        checkVal("alu_pc", bus.PCPlus4_W, 32'h5554);
        checkVal("alu_regwrite", {31'd0, bus.RegWrite_W}, 32'd1);
        checkVal("alu_rd", {27'd0, bus.Rd_W}, 32'd9);
        checkVal("alu_fault", {31'd0, bus.MisalignFault_W}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
